fastica_iter_controller: RTL

Parametrised sequencer for one FastICA unit. It drives the fill/stream/drain enable pattern of an M-stage multiplier pipeline, then a mean window of N samples, then the subtract, normalise and convergence-check steps. It repeats this iteration until the checker reports convergence or an iteration limit is reached. It replaces the fixed 5-stage, 128-sample fast-domain controller and adds multi-iteration looping, abort, done and timeout reporting.

---
 rtl/fastica_iter_controller_if.sv | 32 +++
 rtl/fastica_iter_controller.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fastica_iter_controller_if.sv
// Handshake and enable bundle between a FastICA unit and its iteration sequencer.
// The master side issues start/abort/converged; the slave (the controller) drives the enables.
interface fastica_iter_controller_if #(
  parameter int MUL_STAGES = 5,
  parameter int ITER_W     = 5
);
  logic                  start;
  logic                  abort;
  logic                  converged;
  logic                  en_b;
  logic [MUL_STAGES-1:0] en_mul;
  logic                  en_mean;
  logic                  en_sub;
  logic                  en_norm;
  logic                  en_check;
  logic                  fast_busy;
  logic                  done;
  logic                  timeout;
  logic [ITER_W-1:0]     iter_cnt;

  modport master (
    output start, abort, converged,
    input  en_b, en_mul, en_mean, en_sub, en_norm, en_check,
    input  fast_busy, done, timeout, iter_cnt
  );

  modport slave (
    input  start, abort, converged,
    output en_b, en_mul, en_mean, en_sub, en_norm, en_check,
    output fast_busy, done, timeout, iter_cnt
  );
endinterface

// File: rtl/fastica_iter_controller.sv
// Multi-iteration FastICA sequencer: fill/stream/drain of an M-stage multiplier pipeline,
// N-sample mean window, then subtract/normalise/check, looping until convergence or MAX_ITER.
module fastica_iter_controller #(
  parameter int MUL_STAGES = 5,
  parameter int N_SAMPLES  = 128,
  parameter int MAX_ITER   = 16,
  parameter int ITER_W     = $clog2(MAX_ITER+1)
) (
  input  logic clk_fast,
  input  logic rst,
  fastica_iter_controller_if.slave bus
);

  localparam int CNT_W = $clog2(N_SAMPLES+1);
  localparam logic [CNT_W-1:0]  LAST_EDGE   = CNT_W'(MUL_STAGES-1);
  localparam logic [CNT_W-1:0]  LAST_STREAM = CNT_W'(N_SAMPLES-MUL_STAGES-1);
  localparam logic [ITER_W-1:0] LAST_ITER   = ITER_W'(MAX_ITER-1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_STREAM, S_DRAIN, S_SUB, S_NORM, S_CHECK, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  logic                  timeout_q, timeout_d;
  logic                  en_b_q, en_b_d;
  logic [MUL_STAGES-1:0] en_mul_q, en_mul_d;
  logic                  en_mean_q, en_mean_d;
  logic                  en_sub_q, en_sub_d;
  logic                  en_norm_q, en_norm_d;
  logic                  en_check_q, en_check_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Next state, sub-counter, iteration count and timeout flag.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    iter_d    = iter_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d   = S_FILL;
        cnt_d     = '0;
        iter_d    = '0;
        timeout_d = 1'b0;
      end
      S_FILL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_EDGE) begin
          state_d = S_STREAM;
          cnt_d   = '0;
        end
      end
      S_STREAM: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STREAM) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_EDGE) begin
          state_d = S_SUB;
          cnt_d   = '0;
        end
      end
      S_SUB:  state_d = S_NORM;
      S_NORM: state_d = S_CHECK;
      S_CHECK: begin
        iter_d = iter_q + ITER_W'(1);
        cnt_d  = '0;
        if (bus.converged) begin
          state_d = S_DONE;
        end else if (iter_q == LAST_ITER) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          state_d = S_FILL;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over every busy-state transition, including the CHECK increment.
    if (bus.abort && state_q != S_IDLE && state_q != S_DONE) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      iter_d    = iter_q;
      timeout_d = timeout_q;
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    en_b_d     = (state_d == S_FILL) || (state_d == S_STREAM);
    en_mean_d  = (state_d == S_STREAM) || (state_d == S_DRAIN);
    en_sub_d   = (state_d == S_SUB);
    en_norm_d  = (state_d == S_NORM);
    en_check_d = (state_d == S_CHECK);
    done_d     = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    en_mul_d   = '0;
    for (int k = 0; k < MUL_STAGES; k++) begin
      en_mul_d[k] = (state_d == S_STREAM)
                 || ((state_d == S_FILL)  && (CNT_W'(k) <= cnt_d))
                 || ((state_d == S_DRAIN) && (CNT_W'(k) >  cnt_d));
    end
  end

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      iter_q     <= '0;
      timeout_q  <= 1'b0;
      en_b_q     <= 1'b0;
      en_mul_q   <= '0;
      en_mean_q  <= 1'b0;
      en_sub_q   <= 1'b0;
      en_norm_q  <= 1'b0;
      en_check_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      iter_q     <= iter_d;
      timeout_q  <= timeout_d;
      en_b_q     <= en_b_d;
      en_mul_q   <= en_mul_d;
      en_mean_q  <= en_mean_d;
      en_sub_q   <= en_sub_d;
      en_norm_q  <= en_norm_d;
      en_check_q <= en_check_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.en_b      = en_b_q;
  assign bus.en_mul    = en_mul_q;
  assign bus.en_mean   = en_mean_q;
  assign bus.en_sub    = en_sub_q;
  assign bus.en_norm   = en_norm_q;
  assign bus.en_check  = en_check_q;
  assign bus.fast_busy = busy_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign bus.iter_cnt  = iter_q;

endmodule
